// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-frame player motion with shift-add step, map collision and wall sliding
module player_motion #(
  parameter int QM   = 12,
  parameter int QN   = 12,
  parameter int MOVE = 80,
  parameter logic [QM+QN-1:0] PX0 = 24'h001800,
  parameter logic [QM+QN-1:0] PY0 = 24'h00D800,
  parameter logic [QM+QN-1:0] FX0 = 24'h000000,
  parameter logic [QM+QN-1:0] FY0 = 24'hFFF000,
  parameter logic [QM+QN-1:0] VX0 = 24'h000800,
  parameter logic [QM+QN-1:0] VY0 = 24'h000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                moveL,
  input  logic                moveR,
  input  logic                moveF,
  input  logic                moveB,
  input  logic                write_new_position,
  input  logic [QM+QN-1:0]    new_playerX,
  input  logic [QM+QN-1:0]    new_playerY,
  input  logic [QM+QN-1:0]    new_facingX,
  input  logic [QM+QN-1:0]    new_facingY,
  input  logic [QM+QN-1:0]    new_vplaneX,
  input  logic [QM+QN-1:0]    new_vplaneY,
  output logic                map_req,
  input  logic                map_gnt,
  output logic [3:0]          map_col,
  output logic [3:0]          map_row,
  input  logic [1:0]          map_val,
  output logic [QM+QN-1:0]    playerX,
  output logic [QM+QN-1:0]    playerY,
  output logic [QM+QN-1:0]    facingX,
  output logic [QM+QN-1:0]    facingY,
  output logic [QM+QN-1:0]    vplaneX,
  output logic [QM+QN-1:0]    vplaneY,
  output logic                busy,
  output logic [1:0]          blocked
);

  localparam int W  = QM + QN;
  localparam int SW = W + 2;
  localparam int AW = W + 10;
  localparam logic [7:0] LP_MOVE  = 8'(MOVE);
  localparam logic [W:0] LP_LIMIT = (W+1)'(16) << QN;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_CHK_X, S_CHK_Y, S_COMMIT} state_t;

  state_t r_state, w_next;
  logic [W-1:0] r_px, r_py, r_fx, r_fy, r_vx, r_vy;
  logic signed [SW-1:0] r_sx, r_sy;
  logic signed [AW-1:0] r_accx, r_accy;
  logic [2:0] r_cnt;
  logic r_bx, r_by;
  logic [1:0] r_blocked;

  logic signed [SW-1:0] w_sx, w_sy, w_fx_ext, w_fy_ext, w_vx2, w_vy2;
  logic signed [AW-1:0] w_addx, w_addy;
  logic [W-1:0] w_dx, w_dy, w_ax;
  logic [W:0] w_nx, w_ny;
  logic w_nx_ok, w_ny_ok, w_load, w_start;

  // Direction vector: facing for F/B, doubled viewplane for R/L; L and B subtract.
  assign w_fx_ext = {{2{r_fx[W-1]}}, r_fx};
  assign w_fy_ext = {{2{r_fy[W-1]}}, r_fy};
  assign w_vx2    = {r_vx[W-1], r_vx, 1'b0};
  assign w_vy2    = {r_vy[W-1], r_vy, 1'b0};

  // Combine buttons with L over R and F over B priority.
  always_comb begin
    w_sx = '0;
    w_sy = '0;
    if (moveF) begin
      w_sx = w_fx_ext;
      w_sy = w_fy_ext;
    end else if (moveB) begin
      w_sx = -w_fx_ext;
      w_sy = -w_fy_ext;
    end
    if (moveL) begin
      w_sx = w_sx - w_vx2;
      w_sy = w_sy - w_vy2;
    end else if (moveR) begin
      w_sx = w_sx + w_vx2;
      w_sy = w_sy + w_vy2;
    end
  end

  assign w_load  = tick & write_new_position;
  assign w_start = tick & ~write_new_position & (r_state == S_IDLE) &
                   ((w_sx != '0) | (w_sy != '0));

  // One shifted partial product per MUL cycle, selected by the step-size bit.
  assign w_addx = LP_MOVE[r_cnt] ? ({{(AW-SW){r_sx[SW-1]}}, r_sx} << r_cnt) : '0;
  assign w_addy = LP_MOVE[r_cnt] ? ({{(AW-SW){r_sy[SW-1]}}, r_sy} << r_cnt) : '0;

  // Displacement in raw position LSBs and the candidate position per axis.
  assign w_dx    = W'(r_accx >>> QN);
  assign w_dy    = W'(r_accy >>> QN);
  assign w_nx    = {r_px[W-1], r_px} + {w_dx[W-1], w_dx};
  assign w_ny    = {r_py[W-1], r_py} + {w_dy[W-1], w_dy};
  assign w_nx_ok = ~w_nx[W] & (w_nx < LP_LIMIT);
  assign w_ny_ok = ~w_ny[W] & (w_ny < LP_LIMIT);
  // Column used for the Y probe follows the X decision so the player slides along walls.
  assign w_ax    = r_bx ? r_px : w_nx[W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and map port; a host overwrite always wins and returns to IDLE.
  always_comb begin
    w_next  = r_state;
    map_req = 1'b0;
    map_col = 4'd0;
    map_row = 4'd0;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_MUL;
      S_MUL:    if (r_cnt == 3'd7) w_next = S_CHK_X;
      S_CHK_X: begin
        if ((w_dx == '0) || !w_nx_ok) begin
          w_next = S_CHK_Y;
        end else begin
          map_req = 1'b1;
          map_col = w_nx[QN+3:QN];
          map_row = r_py[QN+3:QN];
          if (map_gnt) w_next = S_CHK_Y;
        end
      end
      S_CHK_Y: begin
        if ((w_dy == '0) || !w_ny_ok) begin
          w_next = S_COMMIT;
        end else begin
          map_req = 1'b1;
          map_col = w_ax[QN+3:QN];
          map_row = w_ny[QN+3:QN];
          if (map_gnt) w_next = S_COMMIT;
        end
      end
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_load) w_next = S_IDLE;
  end

  // Vector registers, multiplier accumulators and per-axis block decisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px <= PX0; r_py <= PY0;
      r_fx <= FX0; r_fy <= FY0;
      r_vx <= VX0; r_vy <= VY0;
      r_sx <= '0; r_sy <= '0;
      r_accx <= '0; r_accy <= '0;
      r_cnt <= '0;
      r_bx <= 1'b0; r_by <= 1'b0;
      r_blocked <= 2'b00;
    end else if (w_load) begin
      r_px <= new_playerX; r_py <= new_playerY;
      r_fx <= new_facingX; r_fy <= new_facingY;
      r_vx <= new_vplaneX; r_vy <= new_vplaneY;
      r_blocked <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_sx <= w_sx; r_sy <= w_sy;
          r_accx <= '0; r_accy <= '0;
          r_cnt <= '0;
        end
        S_MUL: begin
          r_accx <= r_accx + w_addx;
          r_accy <= r_accy + w_addy;
          r_cnt  <= r_cnt + 3'd1;
        end
        S_CHK_X: begin
          if (w_dx == '0)   r_bx <= 1'b0;
          else if (!w_nx_ok) r_bx <= 1'b1;
          else if (map_gnt)  r_bx <= (map_val != 2'b00);
        end
        S_CHK_Y: begin
          if (w_dy == '0)   r_by <= 1'b0;
          else if (!w_ny_ok) r_by <= 1'b1;
          else if (map_gnt)  r_by <= (map_val != 2'b00);
        end
        S_COMMIT: begin
          if (!r_bx) r_px <= w_nx[W-1:0];
          if (!r_by) r_py <= w_ny[W-1:0];
          r_blocked <= {r_by, r_bx};
        end
        default: ;
      endcase
    end
  end

  assign playerX = r_px;
  assign playerY = r_py;
  assign facingX = r_fx;
  assign facingY = r_fy;
  assign vplaneX = r_vx;
  assign vplaneY = r_vy;
  assign busy    = (r_state != S_IDLE);
  assign blocked = r_blocked;

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - randomized scoreboard bench for player_motion
module tb_player_motion;
  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, tick = 1'b0, write_new_position = 1'b0;
  logic moveL = 1'b0, moveR = 1'b0, moveF = 1'b0, moveB = 1'b0;
  logic [W-1:0] new_playerX = '0, new_playerY = '0, new_facingX = '0;
  logic [W-1:0] new_facingY = '0, new_vplaneX = '0, new_vplaneY = '0;
  logic map_req, map_gnt = 1'b1;
  logic [3:0] map_col, map_row;
  logic [1:0] map_val;
  logic [W-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic busy;
  logic [1:0] blocked;

  logic [1:0] map_mem [16][16];
  assign map_val = map_mem[map_row][map_col];

  player_motion dut (
    .clk(clk), .reset(reset), .tick(tick),
    .moveL(moveL), .moveR(moveR), .moveF(moveF), .moveB(moveB),
    .write_new_position(write_new_position),
    .new_playerX(new_playerX), .new_playerY(new_playerY),
    .new_facingX(new_facingX), .new_facingY(new_facingY),
    .new_vplaneX(new_vplaneX), .new_vplaneY(new_vplaneY),
    .map_req(map_req), .map_gnt(map_gnt), .map_col(map_col), .map_row(map_row),
    .map_val(map_val),
    .playerX(playerX), .playerY(playerY), .facingX(facingX), .facingY(facingY),
    .vplaneX(vplaneX), .vplaneY(vplaneY), .busy(busy), .blocked(blocked)
  );

  typedef struct {
    longint px, py, fx, fy, vx, vy;
    int blk;
    int cyc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] rq[$];
  int errs = 0, checks = 0;
  int stall_left = 0;
  longint m_px = 'h1800, m_py = 'hD800, m_fx = 0, m_fy = -4096, m_vx = 2048, m_vy = 0;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic longint sx24(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: direction from button rules, step = floor(S*MOVE / 2^12), per-axis probes.
  task automatic model_move(input bit L, R, F, B, input int stall, output bit mv, output exp_t e);
    longint sx = 0, sy = 0, dx, dy, nx, ny, ax;
    bit bx, by;
    int nreq = 0;
    if (F) begin sx = m_fx; sy = m_fy; end
    else if (B) begin sx = -m_fx; sy = -m_fy; end
    if (L) begin sx -= 2*m_vx; sy -= 2*m_vy; end
    else if (R) begin sx += 2*m_vx; sy += 2*m_vy; end
    mv = !(sx == 0 && sy == 0);
    e = '{default: 0};
    if (!mv) return;
    dx = (sx * 80) >>> 12;
    dy = (sy * 80) >>> 12;
    nx = m_px + dx;
    ny = m_py + dy;
    if (dx == 0) bx = 0;
    else if (nx < 0 || nx >= 65536) bx = 1;
    else begin
      rq.push_back({4'(nx >>> 12), 4'(m_py >>> 12)});
      nreq++;
      bx = (map_mem[int'(m_py >>> 12)][int'(nx >>> 12)] != 0);
    end
    ax = bx ? m_px : nx;
    if (dy == 0) by = 0;
    else if (ny < 0 || ny >= 65536) by = 1;
    else begin
      rq.push_back({4'(ax >>> 12), 4'(ny >>> 12)});
      nreq++;
      by = (map_mem[int'(ny >>> 12)][int'(ax >>> 12)] != 0);
    end
    if (!bx) m_px = nx;
    if (!by) m_py = ny;
    e.px = m_px; e.py = m_py;
    e.fx = m_fx; e.fy = m_fy; e.vx = m_vx; e.vy = m_vy;
    e.blk = {by, bx};
    e.cyc = 11 + ((nreq > 0) ? stall : 0);
  endtask

  // Monitor: grant driver, request scoreboard and commit scoreboard.
  exp_t me;
  bit prev_busy = 0, prev_req = 0, prev_gnt = 1;
  logic [3:0] prev_col = '0, prev_row = '0;
  int busy_cnt = 0;
  logic [7:0] rqe;
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 0; busy_cnt = 0; prev_req = 0; prev_gnt = 1; map_gnt = 1'b1;
    end else begin
      if (busy) busy_cnt++;
      else if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_commit: got busy fall expected none");
        end else begin
          me = sb.pop_front();
          check("commit_px", longint'(playerX), me.px);
          check("commit_py", longint'(playerY), me.py);
          check("commit_blk", longint'(blocked), me.blk);
          check("busy_cycles", busy_cnt, me.cyc);
          check("keep_fx", sx24(facingX), me.fx);
          check("keep_fy", sx24(facingY), me.fy);
          check("keep_vx", sx24(vplaneX), me.vx);
          check("keep_vy", sx24(vplaneY), me.vy);
        end
        busy_cnt = 0;
      end
      if (map_req && stall_left > 0) begin map_gnt = 1'b0; stall_left--; end
      else map_gnt = 1'b1;
      if (!map_req) begin
        check("idle_col", map_col, 0);
        check("idle_row", map_row, 0);
      end else if (prev_req && !prev_gnt) begin
        check("stall_col", map_col, prev_col);
        check("stall_row", map_row, prev_row);
      end
      if (map_req && map_gnt) begin
        if (rq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_req: got col %0d row %0d expected none", map_col, map_row);
        end else begin
          rqe = rq.pop_front();
          check("req_colrow", {map_col, map_row}, rqe);
        end
      end
      prev_busy = busy; prev_req = map_req; prev_gnt = map_gnt;
      prev_col = map_col; prev_row = map_row;
    end
  end

  task automatic host_load(input longint px, py, fx, fy, vx, vy);
    new_playerX = W'(px); new_playerY = W'(py);
    new_facingX = W'(fx); new_facingY = W'(fy);
    new_vplaneX = W'(vx); new_vplaneY = W'(vy);
    tick = 1'b1; write_new_position = 1'b1;
    @(negedge clk);
    tick = 1'b0; write_new_position = 1'b0;
    check("load_px", longint'(playerX), px);
    check("load_py", longint'(playerY), py);
    check("load_fx", sx24(facingX), fx);
    check("load_fy", sx24(facingY), fy);
    check("load_vx", sx24(vplaneX), vx);
    check("load_vy", sx24(vplaneY), vy);
    check("load_blk", blocked, 0);
    m_px = px; m_py = py; m_fx = fx; m_fy = fy; m_vx = vx; m_vy = vy;
  endtask

  task automatic tick_move(input bit L, R, F, B, input int stall, input int extra_at);
    exp_t e;
    bit mv;
    stall_left = stall;
    model_move(L, R, F, B, stall, mv, e);
    if (mv) sb.push_back(e);
    moveL = L; moveR = R; moveF = F; moveB = B; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; moveL = 0; moveR = 0; moveF = 0; moveB = 0;
    if (mv) begin
      if (extra_at > 0) begin
        repeat (extra_at - 1) @(negedge clk);
        tick = 1'b1; moveF = 1'b1; moveL = 1'b1;
        @(negedge clk);
        tick = 1'b0; moveF = 1'b0; moveL = 1'b0;
      end
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      check("move_done", sb.size(), 0);
    end else begin
      repeat (3) @(negedge clk);
      check("nomove_busy", busy, 0);
    end
    check("req_drain", rq.size(), 0);
    sb.delete(); rq.delete(); stall_left = 0;
    @(negedge clk);
  endtask

  task automatic abort_move(input int k, input longint px, py, fx, fy, vx, vy);
    exp_t e;
    e.px = px; e.py = py; e.fx = fx; e.fy = fy; e.vx = vx; e.vy = vy;
    e.blk = 0; e.cyc = k;
    sb.push_back(e);
    moveF = 1'b1; tick = 1'b1;
    @(negedge clk);
    moveF = 1'b0; tick = 1'b0;
    repeat (k - 1) @(negedge clk);
    host_load(px, py, fx, fy, vx, vy);
    check("abort_busy", busy, 0);
    @(negedge clk);
    check("abort_done", sb.size(), 0);
    sb.delete(); rq.delete();
  endtask

  longint ftx[8] = '{4096, -4096, 0, 0, 2896, -2896, 2896, -2896};
  longint fty[8] = '{0, 0, 4096, -4096, 2896, 2896, -2896, -2896};

  initial begin
    int fi;
    logic [3:0] btn;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) map_mem[r][c] = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_px", playerX, 'h001800);
    check("rst_py", playerY, 'h00D800);
    check("rst_fx", facingX, 'h000000);
    check("rst_fy", facingY, 'hFFF000);
    check("rst_vx", vplaneX, 'h000800);
    check("rst_vy", vplaneY, 'h000000);
    check("rst_req", map_req, 0);
    check("rst_busy", busy, 0);
    check("rst_blk", blocked, 0);
    @(negedge clk);

    tick_move(0, 0, 1, 0, 0, 0);
    check("fwd_py", playerY, 'h00D7B0);
    check("fwd_px", playerX, 'h001800);
    tick_move(0, 1, 0, 0, 0, 4);
    check("right_px", playerX, 'h001850);

    // Reset while a Y probe is stalled.
    stall_left = 100;
    moveF = 1'b1; tick = 1'b1;
    @(negedge clk);
    moveF = 1'b0; tick = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req", map_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_py", playerY, 'h00D800);
    @(negedge clk);
    reset = 1'b0; stall_left = 0; sb.delete(); rq.delete();
    m_px = 'h1800; m_py = 'hD800; m_fx = 0; m_fy = -4096; m_vx = 2048; m_vy = 0;
    @(negedge clk);

    for (int r = 0; r < 16; r++) map_mem[r][2] = 2'd1;
    host_load('h1FF0, 'hD800, 0, -4096, 2048, 0);
    tick_move(0, 1, 1, 0, 0, 0);
    check("slide_blk", blocked, 2'b01);
    check("slide_px", playerX, 'h001FF0);
    check("slide_py", playerY, 'h00D7B0);
    for (int r = 0; r < 16; r++) map_mem[r][2] = 2'd0;

    host_load('h20, 'hD800, 0, -4096, 2048, 0);
    tick_move(1, 0, 0, 0, 0, 0);
    check("edge_blk", blocked, 2'b01);
    check("edge_px", playerX, 'h000020);

    host_load('h1800, 'hD800, 0, -4096, 2048, 0);
    tick_move(0, 1, 0, 0, 5, 0);
    check("stall_px", playerX, 'h001850);

    abort_move(4, 'h5000, 'h6000, 4096, 0, 0, 2048);

    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          map_mem[r][c] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (it % 5 == 0) begin
        fi = $urandom_range(0, 7);
        host_load($urandom_range(0, 'hFFFF), $urandom_range(0, 'hFFFF),
                  ftx[fi], fty[fi], -fty[fi] / 2, ftx[fi] / 2);
      end
      btn = 4'($urandom_range(0, 15));
      tick_move(btn[3], btn[2], btn[1], btn[0], $urandom_range(0, 3),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end
endmodule
